// File: rtl/seven_seg_pkg.sv
// Shared constants and hex-to-segment table for the 4-digit 7-segment scanner.
// Latency: none (constants and a pure function).
// Backpressure: none.
package seven_seg_pkg;

  // All cathodes high: every segment of the selected digit dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  // All anodes high: no digit selected.
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex code (entry 15 first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
    return SEG_TABLE[code];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low 7-segment cathode pattern.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; all 16 codes have a glyph.
  always_comb begin
    seg_o = hex_to_seg(code_i);
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes four snapshotted hex digits onto a common-anode 7-segment display.
// Latency: an/seg are registered, one cycle after the scan state that selects them.
// Backpressure: none; the score bus is sampled once per frame and never stalled.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 1000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] blank,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_C    = PW'(GUARD);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  // Scan state
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            phase_q, phase_d;
  logic            first_q;

  // Per-frame snapshot of the score bus
  logic [3:0][3:0] snap_dig_q, snap_dig_d;
  logic [3:0]      snap_blank_q, snap_blank_d;

  // Registered display drive
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  logic            presc_end;
  logic            frame_wrap;
  logic            snap_load;
  logic [6:0]      cur_seg;

  seg7_decode u_decode (
    .code_i (snap_dig_q[idx_q]),
    .seg_o  (cur_seg)
  );

  // Prescaler, slot index, frame/blink counters and the frame snapshot.
  always_comb begin
    presc_end  = (presc_q == PRESC_LAST);
    frame_wrap = presc_end && (idx_q == 2'd3);
    // The first cycle out of reset loads too, so frame 0 shows live data.
    snap_load  = frame_wrap || first_q;

    presc_d = presc_end ? '0 : presc_q + 1'b1;
    idx_d   = presc_end ? idx_q + 2'd1 : idx_q;

    frame_d = frame_q;
    phase_d = phase_q;
    if (frame_wrap) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    snap_dig_d   = snap_dig_q;
    snap_blank_d = snap_blank_q;
    if (snap_load) begin
      snap_dig_d   = {digit3, digit2, digit1, digit0};
      snap_blank_d = blank;
    end
  end

  // Anode/cathode selection: guard gap, blink-off phase and blanked digits stay dark.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    // blink is deliberately taken live so a change shows on the next cycle.
    if ((presc_q >= GUARD_C) && !(blink && phase_q) && !snap_blank_q[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = cur_seg;
    end
  end

  // State and output registers; reset aborts the scan immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      phase_q      <= 1'b0;
      first_q      <= 1'b1;
      snap_dig_q   <= '0;
      snap_blank_q <= 4'hF;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      phase_q      <= phase_d;
      first_q      <= 1'b0;
      snap_dig_q   <= snap_dig_d;
      snap_blank_q <= snap_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed vector table, multi-cycle
// sequences (reset, mid-frame change, blink) and a randomized run against a
// cycle-count reference model.
module tb_seven_seg_scanner;

  localparam int RD = 8;
  localparam int G  = 2;
  localparam int BF = 2;
  localparam int FR = 4 * RD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit0 = '0, digit1 = '0, digit2 = '0, digit3 = '0;
  logic [3:0] blank = '0;
  logic       blink = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seven_seg_scanner #(
    .REFRESH_DIV  (RD),
    .GUARD        (G),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .blank  (blank),
    .blink  (blink),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: position in the scan derived purely from cycles since reset.
  int         m_t = 0;
  logic       m_valid = 1'b0;
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;
  logic [15:0] m_dig = '0;
  logic [3:0] m_blank = 4'hF;

  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    case (c)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Drive chosen for scan cycle t (t=0 is the first cycle with reset low).
  function automatic logic [10:0] ref_drive(input int t, input logic [15:0] dig,
                                            input logic [3:0] bl, input logic bk);
    int slot;
    int pos;
    int phase;
    logic [3:0] onehot;
    slot  = (t / RD) % 4;
    pos   = t % RD;
    phase = ((t / FR) / BF) % 2;
    if (pos < G || (bk && phase == 1) || bl[slot])
      return {4'hF, 7'h7F};
    onehot = 4'd1 << slot;
    return {~onehot, ref_seg(dig[slot*4 +: 4])};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: an/seg got %b/%b, want %b/%b", name,
               act[10:7], act[6:0], exp[10:7], exp[6:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic set_digits(input logic [15:0] d);
    {digit3, digit2, digit1, digit0} = d;
  endtask

  task automatic model_step();
    logic [10:0] d;
    if (reset) begin
      m_t     = 0;
      m_an    = 4'hF;
      m_seg   = 7'h7F;
      m_dig   = '0;
      m_blank = 4'hF;
      m_valid = 1'b1;
    end else if (m_valid) begin
      d     = ref_drive(m_t, m_dig, m_blank, blink);
      m_an  = d[10:7];
      m_seg = d[6:0];
      if (m_t == 0 || (m_t % FR) == FR - 1) begin
        m_dig   = {digit3, digit2, digit1, digit0};
        m_blank = blank;
      end
      m_t++;
    end
  endtask

  // One clock: model sees inputs at the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_valid) begin
      check("model", {an, seg}, {m_an, m_seg});
      tests++;
      if (dp !== 1'b1 || $countones(~an) > 1) begin
        fails++;
        $display("FAIL anode_onehot_dp: an=%b dp=%b, want at most one low anode and dp=1", an, dp);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  bl;
    logic        bk;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
  } vec_t;

  localparam int NV = 19;

  initial begin
    vec_t vecs [NV];
    int   lit;
    int   r;

    vecs[0]  = '{16'h0123, 4'b0000, 1'b0, 0, 4'b1110, 7'b0110000};
    vecs[1]  = '{16'h0123, 4'b0000, 1'b0, 1, 4'b1101, 7'b0100100};
    vecs[2]  = '{16'h0123, 4'b0000, 1'b0, 2, 4'b1011, 7'b1111001};
    vecs[3]  = '{16'h0123, 4'b0000, 1'b0, 3, 4'b0111, 7'b1000000};
    vecs[4]  = '{16'h0007, 4'b1110, 1'b0, 0, 4'b1110, 7'b1111000};
    vecs[5]  = '{16'h0007, 4'b1110, 1'b0, 1, 4'b1111, 7'b1111111};
    vecs[6]  = '{16'h0007, 4'b1110, 1'b0, 3, 4'b1111, 7'b1111111};
    vecs[7]  = '{16'hFE1D, 4'b0000, 1'b0, 3, 4'b0111, 7'b0001110};
    vecs[8]  = '{16'hFE1D, 4'b0000, 1'b1, 0, 4'b1110, 7'b0100001};
    vecs[9]  = '{16'hFE1D, 4'b0000, 1'b0, 1, 4'b1101, 7'b1111001};
    vecs[10] = '{16'hCBA9, 4'b0000, 1'b0, 0, 4'b1110, 7'b0010000};
    vecs[11] = '{16'hCBA9, 4'b0000, 1'b0, 1, 4'b1101, 7'b0001000};
    vecs[12] = '{16'hCBA9, 4'b0000, 1'b0, 2, 4'b1011, 7'b0000011};
    vecs[13] = '{16'hCBA9, 4'b0000, 1'b0, 3, 4'b0111, 7'b1000110};
    vecs[14] = '{16'h8654, 4'b0001, 1'b0, 0, 4'b1111, 7'b1111111};
    vecs[15] = '{16'h8654, 4'b0001, 1'b0, 1, 4'b1101, 7'b0010010};
    vecs[16] = '{16'h8654, 4'b0001, 1'b0, 2, 4'b1011, 7'b0000010};
    vecs[17] = '{16'h8654, 4'b0001, 1'b0, 3, 4'b0111, 7'b0000000};
    vecs[18] = '{16'h000E, 4'b0000, 1'b0, 0, 4'b1110, 7'b0000110};

    // Reset held 3 cycles, then two guard cycles before digit0 lights.
    set_digits(16'h0123);
    blank = 4'b0000;
    blink = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_dark", {an, seg}, {4'hF, 7'h7F});
    end
    reset = 1'b0;
    tick();
    check("guard_cycle0", {an, seg}, {4'hF, 7'h7F});
    tick();
    check("guard_cycle1", {an, seg}, {4'hF, 7'h7F});
    tick();
    check("first_slot_lit", {an, seg}, {4'b1110, 7'b0110000});

    // Directed vectors: mid-slot sample of the requested slot in frame 0.
    for (int i = 0; i < NV; i++) begin
      set_digits(vecs[i].dig);
      blank = vecs[i].bl;
      blink = vecs[i].bk;
      do_reset();
      repeat (RD * vecs[i].slot + G + 3) tick();
      check($sformatf("vec%0d", i), {an, seg}, {vecs[i].an, vecs[i].seg});
    end

    // Mid-frame change of digit0 only shows after the next frame wrap.
    set_digits(16'h0004);
    blank = 4'b0000;
    blink = 1'b0;
    do_reset();
    repeat (5) tick();
    check("snap_initial_4", {an, seg}, {4'b1110, 7'b0011001});
    repeat (15) tick();
    digit0 = 4'h5;
    repeat (17) tick();
    check("snap_after_wrap_5", {an, seg}, {4'b1110, 7'b0010010});
    digit0 = 4'h6;
    repeat (2) tick();
    check("snap_hold_in_slot0", {an, seg}, {4'b1110, 7'b0010010});
    repeat (30) tick();
    check("snap_next_frame_6", {an, seg}, {4'b1110, 7'b0000010});

    // Game-over blink: 2 frames lit, 2 frames dark, repeating.
    set_digits(16'hFE1D);
    blank = 4'b0000;
    blink = 1'b1;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      lit = 0;
      repeat (FR) begin
        tick();
        if (an !== 4'hF) lit++;
      end
      check_int($sformatf("blink_frame%0d_lit_cycles", f), lit,
                (((f / BF) % 2) == 0) ? 4 * (RD - G) : 0);
    end

    // Randomized run with occasional bus changes, blink toggles and resets.
    set_digits(16'($urandom));
    blank = 4'b0000;
    blink = 1'b0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick();
      r = $urandom_range(0, 99);
      if (r < 3) set_digits(16'($urandom));
      if (r == 10) blank = 4'($urandom);
      if (r == 11) blank = 4'b0000;
      if (r == 20) blink = ~blink;
      reset = ($urandom_range(0, 249) == 0);
    end
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
